// File: rtl/cam_seq_pkg.sv
// Shared types for the camera power-up sequencer.
//   CNT_W           : width of the step/watchdog counter
//   cam_seq_state_t : sequencer state encoding (also exported on seq_state)
package cam_seq_pkg;

  localparam int unsigned CNT_W = 24;

  typedef enum logic [2:0] {
    WAIT_SYS = 3'd0,
    PWDN     = 3'd1,
    RESET    = 3'd2,
    SETTLE   = 3'd3,
    CFG_REQ  = 3'd4,
    CFG_WAIT = 3'd5,
    READY    = 3'd6,
    FAIL     = 3'd7
  } cam_seq_state_t;

endpackage

// File: rtl/cam_seq_timer.sv
// Step timer for the camera sequencer: clearable, enabled up-counter that
// saturates at all-ones and flags when it equals the supplied terminal value.
//   clk_i      : clock
//   rst_n_i    : synchronous active-low reset
//   clr_i      : clear count to zero (priority over enable)
//   en_i       : count enable
//   term_val_i : terminal compare value
//   cnt_o      : current count
//   term_o     : cnt_o == term_val_i
module cam_seq_timer
  import cam_seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/cam_power_sequencer.sv
// Camera power-up sequencer. After init_done, holds the sensor in power-down,
// then in reset, lets it settle, pulses cfg_start to the register-config block
// and reports seq_ready once cfg_done returns.
// Optional feature macro: CAM_CFG_TIMEOUT_EN enables a cfg_done watchdog with
// MAX_RETRY full re-sequences before entering FAIL (seq_fail=1). Without it
// CFG_WAIT waits indefinitely and seq_fail is constant 0.
// Ports:
//   clk, rst_n (sync, active low), init_done (level, low forces restart),
//   restart (pulse, honoured in READY/FAIL), cfg_done (sampled in CFG_WAIT),
//   cam_pwdn, cam_rst_n, cfg_start (1-cycle pulse), seq_ready, seq_fail,
//   seq_state (debug state encoding). All outputs registered.
module cam_power_sequencer
  import cam_seq_pkg::*;
#(
  parameter logic [CNT_W-1:0] PWDN_CYCLES        = 24'd50000,
  parameter logic [CNT_W-1:0] RST_CYCLES         = 24'd1000000,
  parameter logic [CNT_W-1:0] SETTLE_CYCLES      = 24'd1000000,
  parameter logic [CNT_W-1:0] CFG_TIMEOUT_CYCLES = 24'd5000000,
  parameter int unsigned      MAX_RETRY          = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_done,
  input  logic       restart,
  input  logic       cfg_done,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       cfg_start,
  output logic       seq_ready,
  output logic       seq_fail,
  output logic [2:0] seq_state
);

  if ((PWDN_CYCLES == '0) || (RST_CYCLES == '0) || (SETTLE_CYCLES == '0) ||
      (CFG_TIMEOUT_CYCLES == '0)) begin : g_bad_cycles
    $error("cam_power_sequencer: cycle counts must be >= 1");
  end
  if (MAX_RETRY > 255) begin : g_bad_retry
    $error("cam_power_sequencer: MAX_RETRY must fit the 8-bit retry counter");
  end

  cam_seq_state_t   state_q, state_d;
  logic             cam_pwdn_q, cam_rst_n_q, cfg_start_q, seq_ready_q;
  logic [CNT_W-1:0] term_val;
  logic [CNT_W-1:0] cnt;
  logic             term;
  logic             cnt_en;
  logic             cnt_clr;

`ifdef CAM_CFG_TIMEOUT_EN
  logic [7:0] retry_q;
  logic       seq_fail_q;
`endif

  always_comb begin
    term_val = '0;
    unique case (state_q)
      PWDN:     term_val = PWDN_CYCLES - CNT_W'(1);
      RESET:    term_val = RST_CYCLES - CNT_W'(1);
      SETTLE:   term_val = SETTLE_CYCLES - CNT_W'(1);
      CFG_WAIT: term_val = CFG_TIMEOUT_CYCLES - CNT_W'(1);
      default:  term_val = '0;
    endcase
  end

  always_comb begin
    cnt_en = (state_q == PWDN) || (state_q == RESET) || (state_q == SETTLE);
`ifdef CAM_CFG_TIMEOUT_EN
    cnt_en = cnt_en || (state_q == CFG_WAIT);
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_SYS: if (init_done) state_d = PWDN;
      PWDN:     if (term) state_d = RESET;
      RESET:    if (term) state_d = SETTLE;
      SETTLE:   if (term) state_d = CFG_REQ;
      CFG_REQ:  state_d = CFG_WAIT;
      CFG_WAIT: begin
        if (cfg_done) begin
          state_d = READY;
        end
`ifdef CAM_CFG_TIMEOUT_EN
        else if (term) begin
          state_d = (retry_q < 8'(MAX_RETRY)) ? PWDN : FAIL;
        end
`endif
      end
      READY:    if (restart) state_d = PWDN;
      FAIL:     if (restart) state_d = PWDN;
      default:  state_d = WAIT_SYS;
    endcase
    // Losing init_done aborts everything, including a same-cycle restart/cfg_done.
    if (!init_done) state_d = WAIT_SYS;
  end

  // Every state change restarts the step timer, so each state times from zero.
  assign cnt_clr = (state_d != state_q);

  cam_seq_timer u_timer (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .term_val_i (term_val),
    .cnt_o      (cnt),
    .term_o     (term)
  );

  // Outputs are decoded from the next state so they change on the entry edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_SYS;
      cam_pwdn_q  <= 1'b1;
      cam_rst_n_q <= 1'b0;
      cfg_start_q <= 1'b0;
      seq_ready_q <= 1'b0;
`ifdef CAM_CFG_TIMEOUT_EN
      seq_fail_q  <= 1'b0;
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cam_pwdn_q  <= (state_d == WAIT_SYS) || (state_d == PWDN) || (state_d == FAIL);
      cam_rst_n_q <= (state_d == SETTLE) || (state_d == CFG_REQ) ||
                     (state_d == CFG_WAIT) || (state_d == READY);
      cfg_start_q <= (state_d == CFG_REQ);
      seq_ready_q <= (state_d == READY);
`ifdef CAM_CFG_TIMEOUT_EN
      seq_fail_q  <= (state_d == FAIL);
      if ((state_d == WAIT_SYS) || (state_d == READY) ||
          ((state_q == FAIL) && (state_d == PWDN))) begin
        retry_q <= '0;
      end else if ((state_q == CFG_WAIT) && (state_d == PWDN)) begin
        retry_q <= retry_q + 8'd1;
      end
`endif
    end
  end

  assign cam_pwdn  = cam_pwdn_q;
  assign cam_rst_n = cam_rst_n_q;
  assign cfg_start = cfg_start_q;
  assign seq_ready = seq_ready_q;
  assign seq_state = state_q;
`ifdef CAM_CFG_TIMEOUT_EN
  assign seq_fail  = seq_fail_q;
`else
  assign seq_fail  = 1'b0;
`endif

  // The raw count is only consumed through the terminal compare.
  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_cam_power_sequencer.sv
// Self-checking bench for cam_power_sequencer with short timing parameters.
module tb_cam_power_sequencer;

  localparam int PW   = 4;
  localparam int RS   = 8;
  localparam int SE   = 16;
  localparam int TO   = 32;
  localparam int MAXR = 2;
  localparam int T_REQ  = PW + RS + SE;  // cycles from sequence start to cfg_start
  localparam int T_WAIT = T_REQ + 1;     // first cycle of waiting for cfg_done
`ifdef CAM_CFG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, init_done, restart, cfg_done;
  logic       cam_pwdn, cam_rst_n, cfg_start, seq_ready, seq_fail;
  logic [2:0] seq_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cfg_pulses = 0;

  always #5 clk = ~clk;

  cam_power_sequencer #(
    .PWDN_CYCLES        (24'(PW)),
    .RST_CYCLES         (24'(RS)),
    .SETTLE_CYCLES      (24'(SE)),
    .CFG_TIMEOUT_CYCLES (24'(TO)),
    .MAX_RETRY          (MAXR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .restart   (restart),
    .cfg_done  (cfg_done),
    .cam_pwdn  (cam_pwdn),
    .cam_rst_n (cam_rst_n),
    .cfg_start (cfg_start),
    .seq_ready (seq_ready),
    .seq_fail  (seq_fail),
    .seq_state (seq_state)
  );

  // Reference model: a sequence is a timeline measured in cycles since it started.
  bit m_run, m_ready, m_fail;
  int m_t, m_retry;

  always @(posedge clk) begin
    if (!rst_n || !init_done) begin
      m_run = 0; m_ready = 0; m_fail = 0; m_retry = 0; m_t = 0;
    end else if (m_ready) begin
      if (restart) begin m_ready = 0; m_run = 1; m_t = 0; end
    end else if (m_fail) begin
      if (restart) begin m_fail = 0; m_retry = 0; m_run = 1; m_t = 0; end
    end else if (!m_run) begin
      m_run = 1; m_t = 0;
    end else if (m_t >= T_WAIT && cfg_done) begin
      m_run = 0; m_ready = 1; m_retry = 0;
    end else if (TO_EN && m_t == T_WAIT + TO - 1) begin
      if (m_retry < MAXR) begin m_retry++; m_t = 0; end
      else begin m_run = 0; m_fail = 1; end
    end else begin
      m_t++;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int es;
    if (m_ready)                es = 6;
    else if (m_fail)            es = 7;
    else if (!m_run)            es = 0;
    else if (m_t < PW)          es = 1;
    else if (m_t < PW + RS)     es = 2;
    else if (m_t < T_REQ)       es = 3;
    else if (m_t == T_REQ)      es = 4;
    else                        es = 5;
    chk_eq("cam_pwdn",  32'(cam_pwdn),  32'(!m_ready && !(m_run && m_t >= PW)));
    chk_eq("cam_rst_n", 32'(cam_rst_n), 32'(m_ready || (m_run && m_t >= PW + RS)));
    chk_eq("cfg_start", 32'(cfg_start), 32'(m_run && m_t == T_REQ));
    chk_eq("seq_ready", 32'(seq_ready), 32'(m_ready));
    chk_eq("seq_fail",  32'(seq_fail),  32'(m_fail));
    chk_eq("seq_state", 32'(seq_state), 32'(es));
  endtask

  // Called at a negedge: drive inputs, wait one cycle, compare.
  task automatic step(input logic r, input logic i, input logic rs, input logic cd);
    rst_n = r; init_done = i; restart = rs; cfg_done = cd;
    @(negedge clk);
    if (cfg_start) n_cfg_pulses++;
    check_all();
  endtask

  // Run with cfg_done pulsed at timeline cycle cd_t until READY or budget expiry.
  task automatic run_to_ready(input string tag, input int cd_t, input int budget);
    int k;
    for (k = 0; k < budget && !m_ready; k++)
      step(1, 1, 0, m_run && m_t == cd_t);
    chk_eq(tag, 32'(seq_ready), 32'd1);
  endtask

  initial begin
    rst_n = 0; init_done = 0; restart = 0; cfg_done = 0;
    @(negedge clk);
    // 1: reset then init_done low for 100 cycles
    repeat (3) step(0, 0, 0, 0);
    chk_eq("reset_state", 32'(seq_state), 32'd0);
    repeat (100) step(1, 0, 0, 0);
    chk_eq("idle_pwdn", 32'(cam_pwdn), 32'd1);

    // 2: edge timing after init_done is sampled at E0
    step(1, 1, 0, 0);
    for (int e = 1; e <= 29; e++) begin
      step(1, 1, 0, 0);
      if (e == 3)  chk_eq("pwdn_E3",  32'(cam_pwdn), 32'd1);
      if (e == 4)  chk_eq("pwdn_E4",  32'(cam_pwdn), 32'd0);
      if (e == 11) chk_eq("rstn_E11", 32'(cam_rst_n), 32'd0);
      if (e == 12) chk_eq("rstn_E12", 32'(cam_rst_n), 32'd1);
      if (e == 27) chk_eq("cfg_E27",  32'(cfg_start), 32'd0);
      if (e == 28) chk_eq("cfg_E28",  32'(cfg_start), 32'd1);
      if (e == 29) chk_eq("cfg_E29",  32'(cfg_start), 32'd0);
    end

    // 3: cfg_done 10 cycles after cfg_start, then extra cfg_done ignored
    run_to_ready("ready_1", T_REQ + 10, 40);
    repeat (5) step(1, 1, 0, 1);
    chk_eq("ready_hold", 32'(seq_ready), 32'd1);

    // 4: restart in READY; restart during SETTLE ignored
    step(1, 1, 1, 0);
    chk_eq("restart_pwdn",  32'(cam_pwdn), 32'd1);
    chk_eq("restart_ready", 32'(seq_ready), 32'd0);
    for (int k = 0; k < 60 && !m_ready; k++)
      step(1, 1, m_run && m_t == 20, m_run && m_t == T_REQ + 10);
    chk_eq("ready_2", 32'(seq_ready), 32'd1);

    // 5: init_done dropped mid-RESET, then together with restart in READY
    step(1, 1, 1, 0);
    for (int k = 0; k < 20 && m_t != PW + 2; k++) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk_eq("drop_reset_state", 32'(seq_state), 32'd0);
    run_to_ready("ready_3", T_REQ + 3, 60);
    step(1, 0, 1, 1);
    chk_eq("drop_ready_state", 32'(seq_state), 32'd0);
    chk_eq("drop_ready_pwdn",  32'(cam_pwdn), 32'd1);

    // 6: cfg_done never returns
    n_cfg_pulses = 0;
    repeat (250) step(1, 1, 0, 0);
    chk_eq("cfg_pulse_count", 32'(n_cfg_pulses), TO_EN ? 32'd3 : 32'd1);
    chk_eq("fail_flag", 32'(seq_fail), 32'(TO_EN));
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    // cfg_done exactly on the watchdog's terminal cycle
    run_to_ready("ready_terminal", T_WAIT + TO - 1, 120);

    // Random phase
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 199) != 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 24) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
